// File: rtl/counter_pkg.sv
// counter_pkg: shared FSM state type for the modulo counter
package counter_pkg;
  localparam int STATE_W = 2;
  typedef enum logic [STATE_W-1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/counter_step.sv
// counter_step: combinational next-value and terminal-event logic for a modulo count
module counter_step #(
  parameter int     WIDTH   = 8,
  parameter longint MODULUS = longint'(1) << WIDTH
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up,
  output logic [WIDTH-1:0] nxt,
  output logic             term
);
  localparam logic [WIDTH:0] MAX = (WIDTH+1)'(MODULUS - 1);
  logic [WIDTH:0] ext, sum;
  always_comb begin
    ext  = {1'b0, count};
    sum  = up ? ext + 1'b1 : ext - 1'b1;
    term = up ? ext == MAX : ext == '0;
    nxt  = term ? (up ? '0 : MAX[WIDTH-1:0]) : sum[WIDTH-1:0];
  end
endmodule

// File: rtl/mod_counter.sv
// mod_counter: up/down modulo counter with load, enable and one-shot FSM; COUNTER_DISPLAY_EN adds a count trace
module mod_counter
  import counter_pkg::*;
#(
  parameter int     WIDTH   = 8,
  parameter longint MODULUS = longint'(1) << WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             oneshot,
  input  logic             start,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done
);
  localparam logic [WIDTH:0] MAX = (WIDTH+1)'(MODULUS - 1);
  state_t           state;
  logic             mode;
  logic             step, term;
  logic [WIDTH-1:0] nxt, clamp;
  counter_step #(.WIDTH(WIDTH), .MODULUS(MODULUS)) u_step (
    .count(count),
    .up   (up),
    .nxt  (nxt),
    .term (term)
  );
  // one-shot mode only advances while a run is active
  assign step  = en && (!mode || state == RUN);
  assign clamp = ({1'b0, load_val} > MAX) ? MAX[WIDTH-1:0] : load_val;
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      tc    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      state <= IDLE;
      mode  <= 1'b0;
    end else begin
      tc   <= 1'b0;
      done <= 1'b0;
      if (load) count <= clamp;
      else if (step) begin
        count <= (mode && term) ? count : nxt;
        tc    <= term;
      end
      case (state)
        IDLE: if (start) begin
          mode <= oneshot;
          if (oneshot) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: if (step && !load && term) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef COUNTER_DISPLAY_EN
  always @(posedge clk) $display("count=%0d", count);
`endif
endmodule

// File: tb/tb_mod_counter.sv
// tb_mod_counter: randomized scoreboard bench for mod_counter against a behavioural model
module tb_mod_counter;
  localparam int W = 8;
  localparam int M = 10;
  typedef struct packed {
    logic [W-1:0] count;
    logic         tc, busy, done;
  } exp_t;
  logic         clk, rst, en, up, load, oneshot, start;
  logic [W-1:0] load_val, count;
  logic         tc, busy, done;
  exp_t         q[$];
  int           checks = 0, errors = 0;
  int           m_count = 0;
  bit           m_oneshot = 0, m_running = 0, m_finishing = 0;
  mod_counter #(.WIDTH(W), .MODULUS(M)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .oneshot(oneshot), .start(start), .count(count), .tc(tc), .busy(busy), .done(done)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  // applies one cycle of inputs, predicts the post-edge outputs and queues them
  task automatic cyc(bit r, bit e, bit u, bit l, logic [W-1:0] lv, bit os, bit st);
    exp_t x;
    bit stepping, terminal, was_run, was_fin;
    rst = r; en = e; up = u; load = l; load_val = lv; oneshot = os; start = st;
    x.tc = 0;
    if (r) begin
      m_count = 0; m_oneshot = 0; m_running = 0; m_finishing = 0;
    end else begin
      was_run  = m_running;
      was_fin  = m_finishing;
      stepping = e && (!m_oneshot || was_run);
      terminal = u ? (m_count == M - 1) : (m_count == 0);
      m_finishing = 0;
      if (l) m_count = (int'(lv) > M - 1) ? M - 1 : int'(lv);
      else if (stepping) begin
        if (!(terminal && m_oneshot)) m_count = (m_count + (u ? 1 : M - 1)) % M;
        x.tc = terminal;
      end
      if (!was_run && !was_fin && st) begin
        m_oneshot = os;
        m_running = os;
      end
      if (was_run && stepping && !l && terminal) begin
        m_running   = 0;
        m_finishing = 1;
      end
    end
    x.count = W'(m_count);
    x.busy  = m_running;
    x.done  = m_finishing;
    @(posedge clk);
    q.push_back(x);
    #1;
  endtask
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        x = q.pop_front();
        checks++;
        if ({count, tc, busy, done} !== x) begin
          errors++;
          $display("FAIL outputs t=%0t: count=%0d tc=%b busy=%b done=%b, expected count=%0d tc=%b busy=%b done=%b",
                   $time, count, tc, busy, done, x.count, x.tc, x.busy, x.done);
        end
      end
    end
  end
  initial begin
    rst = 1; en = 0; up = 1; load = 0; load_val = 0; oneshot = 0; start = 0;
    repeat (2) cyc(1, 0, 1, 0, 0, 0, 0);
    repeat (11) cyc(0, 1, 1, 0, 0, 0, 0);
    repeat (3) cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 1, 8'd200, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 8'd4, 0, 0);
    repeat (3) cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 8'd7, 0, 0);
    cyc(0, 0, 1, 0, 0, 1, 1);
    repeat (5) cyc(0, 1, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 8'd3, 0, 0);
    cyc(0, 0, 1, 0, 0, 1, 1);
    repeat (2) cyc(0, 1, 1, 0, 0, 0, 1);
    cyc(1, 1, 1, 0, 0, 0, 1);
    repeat (3) cyc(0, 1, 0, 0, 0, 0, 0);
    repeat (3000)
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 19) == 0, W'($urandom), 1'($urandom), $urandom_range(0, 9) == 0);
    repeat (2) @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
